// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Operand/result bundle for the bit-serial subtractor.
//   master: drives start, a, b; observes busy, done, diff, borrow_out, overflow.
//   slave : the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first two's-complement subtractor: diff = a - b over WIDTH
//   cycles using one full-subtractor cell and a registered borrow. Results are
//   held in dedicated output registers until the next completion.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of serial_subtractor_if
//            start (in), a/b (in, captured on accept),
//            busy/done (out), diff/borrow_out/overflow (out, held)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per cycle through the full-subtractor cell
// DONE  | one-cycle result pulse; start here is accepted back-to-back
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             a_msb;
    logic             b_msb;
    logic             borrow_q;
    logic             ovf_q;
    logic             accept;
    logic             last;
    logic             d;
    logic             bor_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        accept   = 1'b0;
        last     = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                accept = bus.start;
                if (bus.start) state_nx = RUN;
            end
            RUN: begin
                last = (cnt == CNT_LAST);
                if (last) state_nx = DONE;
            end
            DONE: begin
                accept   = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d      = sa[0] ^ sb[0] ^ bor;
        bor_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa       <= '0;
            sb       <= '0;
            pr       <= '0;
            cnt      <= '0;
            bor      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a;
            sb    <= bus.b;
            cnt   <= '0;
            bor   <= 1'b0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            pr  <= {d, pr[WIDTH-1:1]};
            bor <= bor_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                // d is the result MSB on this final bit-cycle.
                diff_q   <= {d, pr[WIDTH-1:1]};
                borrow_q <= bor_nx;
                ovf_q    <= (a_msb ^ b_msb) & (d ^ a_msb);
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor computing diff = a − b over WIDTH cycles using one full-subtractor cell and a registered borrow. It is the inverse arithmetic companion to the board-level full-adder datapath. It sits behind switch- or controller-driven operands on the DE1_SoC top level and reports a held result plus unsigned-borrow and signed-overflow flags to LEDs or HEX decoders.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk, accepted only when busy = 0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while a subtraction is in progress (state RUN).
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- diff  output  WIDTH  (a − b) mod 2^WIDTH; held until the next done.
- borrow_out  output  1  final borrow; equals 1 iff a < b unsigned.
- overflow  output  1  signed overflow: a[MSB] ≠ b[MSB] and diff[MSB] ≠ a[MSB].

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start = 1, go to RUN.
  - RUN: after WIDTH bit-cycles, go to DONE.
  - DONE: on start = 1, go to RUN; otherwise go to IDLE.
- Accept edge (IDLE or DONE with start = 1):
  - Load shift registers sa <= a and sb <= b.
  - Clear running borrow bor <= 0 and bit counter cnt <= 0.
  - Latch a[WIDTH-1] and b[WIDTH-1] for the overflow check.
- RUN, each edge:
  - d = sa[0] ^ sb[0] ^ bor.
  - bor <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor).
  - Shift sa and sb right by 1.
  - Shift d into the MSB of the partial-result register, which shifts right.
  - cnt <= cnt + 1.
  - On the edge where cnt = WIDTH−1, copy the completed partial result into diff, set borrow_out from the final borrow, compute overflow, and go to DONE.
- diff, borrow_out and overflow are separate output registers. They change only on the completion edge, so the previous result stays stable throughout RUN.
- start while in RUN is ignored; it is neither queued nor latched.
- No arithmetic widening: the result is strictly WIDTH bits. The carry/borrow information is exposed only through borrow_out.

## Timing
- Reset (async assert, synchronous-release design): state = IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0, cnt = 0, bor = 0.
- Reset mid-RUN aborts immediately. Outputs return to their reset values and no done pulse is produced.
- Call the accept edge E0.
  - busy = 1 from E0 through E(WIDTH).
  - diff and flags update at edge E(WIDTH).
  - done = 1 for exactly the cycle following E(WIDTH).
  - Latency start → done = WIDTH cycles.
- busy and done are never both 1. done is registered, not decoded from start.
- Back-to-back: start held high during DONE is accepted at that edge. The next done occurs WIDTH+1 cycles after the previous done, which is the maximum throughput.
- start held continuously high produces one operation per WIDTH+1 cycles.
- a and b may change freely after E0 without affecting the operation in progress.

## Test plan
- WIDTH = 8, a = 0xC8, b = 0x37, one-cycle start → done 8 cycles later; diff = 0x91, borrow_out = 0, overflow = 0; busy high exactly 8 cycles.
- a = 0x05, b = 0x0A → diff = 0xFB, borrow_out = 1, overflow = 0. Then a = 0x80, b = 0x01 → diff = 0x7F, borrow_out = 0, overflow = 1.
- a = 0x00, b = 0x00 → diff = 0x00, all flags 0. Then a = 0x00, b = 0xFF → diff = 0x01, borrow_out = 1.
- Pulse start again 3 cycles into RUN with different operands → ignored; the original result appears on schedule, and exactly one done pulse is produced.
- Hold start high continuously with operands changing each operation → done pulses spaced exactly 9 cycles apart, each diff matching the operands captured at its own accept edge.
- Assert reset_n = 0 asynchronously 4 cycles into RUN (between clock edges) → all outputs are 0 immediately, and no done appears after release. A new start then completes normally.
- Exhaustive random check at WIDTH = 4: all 256 a/b pairs → diff, borrow_out and overflow each match the reference model.
